// File: rtl/ccd_line_sequencer.sv
// ccd_line_sequencer: line-level CCD timing generator.
// Each line runs a guarded SH transfer pulse, then N pixels of P1/RS/CP
// phase timing. It emits a sample strobe with pixel index for the ADC
// capture block. Lines run once or back-to-back until a graceful stop.
module ccd_line_sequencer #(
  parameter int PIX_PERIOD = 50,
  parameter int CNTR_W     = 8,
  parameter int PIX_W      = 12,
  parameter int P1_HIGH    = 24,
  parameter int P1_LOW     = 0,
  parameter int RS_HIGH    = 16,
  parameter int RS_LOW     = 21,
  parameter int CP_HIGH    = 26,
  parameter int CP_LOW     = 31,
  parameter int SAMPLE_AT  = 40,
  parameter int SH_GUARD   = 10,
  parameter int SH_WIDTH   = 20
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [PIX_W-1:0] line_pixels,
  output logic             busy,
  output logic             ccd_p1,
  output logic             ccd_p2,
  output logic             ccd_sh,
  output logic             ccd_rs,
  output logic             ccd_cp,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_index,
  output logic             line_done,
  output logic [15:0]      line_count
);

  // Parameter sanity, checked while the design is elaborated.
  if (PIX_PERIOD < 8 || PIX_PERIOD > (1 << CNTR_W)) begin : g_bad_period
    $error("ccd_line_sequencer: PIX_PERIOD outside 8..2**CNTR_W");
  end
  if (P1_HIGH >= PIX_PERIOD || P1_LOW >= PIX_PERIOD || RS_HIGH >= PIX_PERIOD ||
      RS_LOW >= PIX_PERIOD || CP_HIGH >= PIX_PERIOD || CP_LOW >= PIX_PERIOD ||
      SAMPLE_AT >= PIX_PERIOD) begin : g_bad_edge
    $error("ccd_line_sequencer: edge position not below PIX_PERIOD");
  end
  if (P1_HIGH == P1_LOW || RS_HIGH == RS_LOW || CP_HIGH == CP_LOW) begin : g_bad_pair
    $error("ccd_line_sequencer: a HIGH edge coincides with its LOW edge");
  end
  if (SH_GUARD < 1 || SH_WIDTH < 1) begin : g_bad_sh
    $error("ccd_line_sequencer: SH_GUARD and SH_WIDTH must be at least 1");
  end

  localparam int SEG_MAX = (SH_GUARD > SH_WIDTH) ? SH_GUARD : SH_WIDTH;
  localparam int SEG_W   = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

  localparam logic [SEG_W-1:0]  GUARD_LAST = SEG_W'(SH_GUARD - 1);
  localparam logic [SEG_W-1:0]  WIDTH_LAST = SEG_W'(SH_WIDTH - 1);
  localparam logic [CNTR_W-1:0] TC_LAST    = CNTR_W'(PIX_PERIOD - 1);
  localparam logic [CNTR_W-1:0] TC_P1_HIGH = CNTR_W'(P1_HIGH);
  localparam logic [CNTR_W-1:0] TC_P1_LOW  = CNTR_W'(P1_LOW);
  localparam logic [CNTR_W-1:0] TC_RS_HIGH = CNTR_W'(RS_HIGH);
  localparam logic [CNTR_W-1:0] TC_RS_LOW  = CNTR_W'(RS_LOW);
  localparam logic [CNTR_W-1:0] TC_CP_HIGH = CNTR_W'(CP_HIGH);
  localparam logic [CNTR_W-1:0] TC_CP_LOW  = CNTR_W'(CP_LOW);
  localparam logic [CNTR_W-1:0] TC_SAMPLE  = CNTR_W'(SAMPLE_AT);

  typedef enum logic [2:0] {
    IDLE,
    SH_PRE,
    SH_PULSE,
    SH_POST,
    READOUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SEG_W-1:0]  seg_cnt;
  logic [CNTR_W-1:0] tc;
  logic [PIX_W-1:0]  pix;
  logic [PIX_W-1:0]  n_q;
  logic              cont_q;
  logic              stop_pending;

  logic             accept;
  logic             tc_last;
  logic             pix_last;
  logic             eol;
  logic             p1_nxt;
  logic             sh_nxt;
  logic             rs_nxt;
  logic             cp_nxt;
  logic             pv_nxt;
  logic [PIX_W-1:0] idx_nxt;
  logic             ld_nxt;

  assign accept   = (state == IDLE) && start && (line_pixels != '0);
  assign tc_last  = (tc == TC_LAST);
  assign pix_last = (pix == (n_q - PIX_W'(1)));
  assign eol      = (state == READOUT) && tc_last && pix_last;
  assign ccd_p2   = ~ccd_p1;

  // State register; reset drops straight back to IDLE even mid-line.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Line sequencing: guard, SH pulse, guard, readout, then repeat or stop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SH_PRE;
      SH_PRE:   if (seg_cnt == GUARD_LAST) state_nxt = SH_PULSE;
      SH_PULSE: if (seg_cnt == WIDTH_LAST) state_nxt = SH_POST;
      SH_POST:  if (seg_cnt == GUARD_LAST) state_nxt = READOUT;
      READOUT:  if (eol) state_nxt = (cont_q && !stop_pending && !stop) ? SH_PRE : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered CCD outputs; outside readout the phases park.
  always_comb begin
    p1_nxt  = 1'b1;
    rs_nxt  = 1'b0;
    cp_nxt  = 1'b0;
    sh_nxt  = (state_nxt == SH_PULSE);
    pv_nxt  = 1'b0;
    idx_nxt = pix_index;
    ld_nxt  = 1'b0;
    if (state == READOUT) begin
      p1_nxt = ccd_p1;
      rs_nxt = ccd_rs;
      cp_nxt = ccd_cp;
      if (tc == TC_P1_HIGH) p1_nxt = 1'b1;
      if (tc == TC_P1_LOW)  p1_nxt = 1'b0;
      if (tc == TC_RS_HIGH) rs_nxt = 1'b1;
      if (tc == TC_RS_LOW)  rs_nxt = 1'b0;
      if (tc == TC_CP_HIGH) cp_nxt = 1'b1;
      if (tc == TC_CP_LOW)  cp_nxt = 1'b0;
      if (tc == TC_SAMPLE) begin
        pv_nxt  = 1'b1;
        idx_nxt = pix;
      end
      if (eol) begin
        ld_nxt = 1'b1;
        p1_nxt = 1'b1;
        rs_nxt = 1'b0;
        cp_nxt = 1'b0;
      end
    end
  end

  // Counters, captured line setup, stop latch and the output registers.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      seg_cnt      <= '0;
      tc           <= '0;
      pix          <= '0;
      n_q          <= '0;
      cont_q       <= 1'b0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      ccd_p1       <= 1'b1;
      ccd_sh       <= 1'b0;
      ccd_rs       <= 1'b0;
      ccd_cp       <= 1'b0;
      pix_valid    <= 1'b0;
      pix_index    <= '0;
      line_done    <= 1'b0;
      line_count   <= '0;
    end else begin
      if ((state_nxt == state) && (state != IDLE) && (state != READOUT))
        seg_cnt <= seg_cnt + SEG_W'(1);
      else
        seg_cnt <= '0;

      if ((state == READOUT) && !tc_last) tc <= tc + CNTR_W'(1);
      else                                tc <= '0;

      if (state != READOUT)  pix <= '0;
      else if (tc_last)      pix <= pix_last ? '0 : pix + PIX_W'(1);

      if (accept) begin
        n_q    <= line_pixels;
        cont_q <= continuous;
      end

      if (accept)                                 stop_pending <= stop;
      else if (state != IDLE && state_nxt == IDLE) stop_pending <= 1'b0;
      else if (state != IDLE && stop)              stop_pending <= 1'b1;

      if (eol) line_count <= line_count + 16'd1;

      busy      <= (state_nxt != IDLE);
      ccd_p1    <= p1_nxt;
      ccd_sh    <= sh_nxt;
      ccd_rs    <= rs_nxt;
      ccd_cp    <= cp_nxt;
      pix_valid <= pv_nxt;
      pix_index <= idx_nxt;
      line_done <= ld_nxt;
    end
  end

endmodule

// File: tb/tb_ccd_line_sequencer.sv
// tb_ccd_line_sequencer: directed bench for ccd_line_sequencer with
// default parameters (50-cycle pixel, 10/20/10 SH timing).
module tb_ccd_line_sequencer;

  logic        clk_100M = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [11:0] line_pixels = '0;
  logic        busy;
  logic        ccd_p1;
  logic        ccd_p2;
  logic        ccd_sh;
  logic        ccd_rs;
  logic        ccd_cp;
  logic        pix_valid;
  logic [11:0] pix_index;
  logic        line_done;
  logic [15:0] line_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        sh;
    logic        p1;
    logic        rs;
    logic        cp;
    logic        pv;
    logic [11:0] idx;
  } exp_t;

  ccd_line_sequencer dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .line_pixels(line_pixels),
    .busy       (busy),
    .ccd_p1     (ccd_p1),
    .ccd_p2     (ccd_p2),
    .ccd_sh     (ccd_sh),
    .ccd_rs     (ccd_rs),
    .ccd_cp     (ccd_cp),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .line_done  (line_done),
    .line_count (line_count)
  );

  // 100 MHz system clock.
  always #5 clk_100M = ~clk_100M;

  // Expected outputs r cycles after a line is accepted, for an n-pixel line.
  function automatic exp_t line_model(input int r, input int n);
    exp_t e;
    int t;
    e = '0;
    e.p1 = 1'b1;
    if (r >= 10 && r < 30) e.sh = 1'b1;
    if (r >= 40 && r < 40 + 50 * n) begin
      t     = (r - 40) % 50;
      e.p1  = !(t >= 1 && t <= 24);
      e.rs  = (t >= 17 && t <= 21);
      e.cp  = (t >= 27 && t <= 31);
      e.pv  = (t == 41);
      e.idx = 12'((r - 40) / 50);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    continuous  = 1'b0;
    line_pixels = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic launch(input logic cont, input logic [11:0] n, input logic with_stop);
    start       = 1'b1;
    continuous  = cont;
    line_pixels = n;
    stop        = with_stop;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    do_reset();
    repeat (100) step();
    got = {ccd_sh, ccd_p1, ccd_p2, ccd_rs, ccd_cp, pix_valid, line_done, busy};
    checks++;
    if (got !== 8'b01000000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b want=01000000", got);
    end
    checks++;
    if (line_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_line_count got=%0d want=0", line_count);
    end
    checks++;
    if (pix_index !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_pix_index got=%0d want=0", pix_index);
    end
  endtask

  task automatic test_single_line();
    exp_t e;
    logic [7:0] got, want;
    do_reset();
    launch(1'b0, 12'd4, 1'b0);
    for (int k = 0; k < 280; k++) begin
      e    = line_model(k, 4);
      got  = {ccd_sh, ccd_p1, ccd_p2, ccd_rs, ccd_cp, pix_valid, line_done, busy};
      want = {e.sh, e.p1, ~e.p1, e.rs, e.cp, e.pv, (k == 240), (k < 240)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL single k=%0d got=%b want=%b", k, got, want);
      end
      if (e.pv) begin
        checks++;
        if (pix_index !== e.idx) begin
          errors++;
          $display("[TB] FAIL single_index k=%0d got=%0d want=%0d", k, pix_index, e.idx);
        end
      end
      step();
    end
    checks++;
    if (line_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL single_line_count got=%0d want=1", line_count);
    end
  endtask

  task automatic test_continuous_stop();
    exp_t e;
    logic [7:0] got, want;
    int r;
    do_reset();
    launch(1'b1, 12'd3, 1'b0);
    for (int k = 0; k < 580; k++) begin
      r    = (k < 190) ? k : k - 190;
      e    = line_model(r, 3);
      got  = {ccd_sh, ccd_p1, ccd_p2, ccd_rs, ccd_cp, pix_valid, line_done, busy};
      want = {e.sh, e.p1, ~e.p1, e.rs, e.cp, e.pv, (k == 190 || k == 380), (k < 380)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL continuous k=%0d got=%b want=%b", k, got, want);
      end
      if (e.pv) begin
        checks++;
        if (pix_index !== e.idx) begin
          errors++;
          $display("[TB] FAIL continuous_index k=%0d got=%0d want=%0d", k, pix_index, e.idx);
        end
      end
      if (k == 300) stop = 1'b1;
      step();
      stop = 1'b0;
    end
    checks++;
    if (line_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL continuous_line_count got=%0d want=2", line_count);
    end
  endtask

  task automatic test_reset_mid_line();
    exp_t e;
    logic [7:0] got, want;
    do_reset();
    launch(1'b0, 12'd4, 1'b0);
    repeat (260) step();
    launch(1'b0, 12'd4, 1'b0);
    repeat (170) step();
    checks++;
    if (ccd_cp !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_cp got=%b want=1", ccd_cp);
    end
    rst_n = 1'b0;
    step();
    got = {ccd_sh, ccd_p1, ccd_p2, ccd_rs, ccd_cp, pix_valid, line_done, busy};
    checks++;
    if (got !== 8'b01000000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got=%b want=01000000", got);
    end
    checks++;
    if (line_count !== 16'd0 || pix_index !== 12'd0) begin
      errors++;
      $display("[TB] FAIL midreset_counts got=%0d/%0d want=0/0", line_count, pix_index);
    end
    rst_n = 1'b1;
    step();
    launch(1'b0, 12'd2, 1'b0);
    for (int k = 0; k < 160; k++) begin
      e    = line_model(k, 2);
      got  = {ccd_sh, ccd_p1, ccd_p2, ccd_rs, ccd_cp, pix_valid, line_done, busy};
      want = {e.sh, e.p1, ~e.p1, e.rs, e.cp, e.pv, (k == 140), (k < 140)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL after_reset k=%0d got=%b want=%b", k, got, want);
      end
      step();
    end
    checks++;
    if (line_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL after_reset_line_count got=%0d want=1", line_count);
    end
  endtask

  task automatic test_ignored_starts();
    exp_t e;
    logic [7:0] got, want;
    do_reset();
    launch(1'b1, 12'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL zero_pixels_busy k=%0d got=%b want=0", k, busy);
      end
      step();
    end
    launch(1'b0, 12'd2, 1'b0);
    for (int k = 0; k < 200; k++) begin
      e    = line_model(k, 2);
      got  = {ccd_sh, ccd_p1, ccd_p2, ccd_rs, ccd_cp, pix_valid, line_done, busy};
      want = {e.sh, e.p1, ~e.p1, e.rs, e.cp, e.pv, (k == 140), (k < 140)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL busy_start k=%0d got=%b want=%b", k, got, want);
      end
      if (k == 50) begin
        start       = 1'b1;
        continuous  = 1'b1;
        line_pixels = 12'd5;
      end
      step();
      start = 1'b0;
    end
    checks++;
    if (line_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL busy_start_line_count got=%0d want=1", line_count);
    end
  endtask

  task automatic test_back_to_back_stop();
    exp_t e;
    logic [7:0] got, want;
    do_reset();
    stop = 1'b1;
    step();
    stop = 1'b0;
    launch(1'b1, 12'd1, 1'b1);
    for (int k = 0; k < 250; k++) begin
      e    = line_model(k, 1);
      got  = {ccd_sh, ccd_p1, ccd_p2, ccd_rs, ccd_cp, pix_valid, line_done, busy};
      want = {e.sh, e.p1, ~e.p1, e.rs, e.cp, e.pv, (k == 90), (k < 90)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL start_stop k=%0d got=%b want=%b", k, got, want);
      end
      step();
    end
    checks++;
    if (line_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL start_stop_line_count got=%0d want=1", line_count);
    end
  endtask

  // Runs every scenario in turn, then prints the summary.
  initial begin
    $display("[TB] ccd_line_sequencer bench starting");
    test_reset();
    test_single_line();
    test_continuous_stop();
    test_reset_mid_line();
    test_ignored_starts();
    test_back_to_back_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
